// File: rtl/cap_alloc_pkg.sv
// Shared definitions for the channel-to-capacitor allocation sequencer.
// Holds the FSM state type, the width/beat helpers used by the top, and the
// derived constants for the default 128-channel / 70-capacitor configuration.
package cap_alloc_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Width of a counter that must hold values 0..ch inclusive.
    function automatic int unsigned cnt_w(input int unsigned ch);
        return $clog2(ch + 1);
    endfunction

    // Width of the step index, which reaches cap at the end of a job.
    function automatic int unsigned idx_w(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

    // Clocks per job: ceil(cap / per).
    function automatic int unsigned num_beats(input int unsigned cap, input int unsigned per);
        return (cap + per - 1) / per;
    endfunction

    localparam int unsigned CHANNEL_NUM_DEF   = 128;
    localparam int unsigned CAPACITOR_NUM_DEF = 70;
    localparam int unsigned STEPS_PER_CYC_DEF = 7;

    localparam int unsigned CNT_W     = $clog2(CHANNEL_NUM_DEF + 1);
    localparam int unsigned IDX_W     = $clog2(CAPACITOR_NUM_DEF + 1);
    localparam int unsigned NUM_BEATS =
        (CAPACITOR_NUM_DEF + STEPS_PER_CYC_DEF - 1) / STEPS_PER_CYC_DEF;

endpackage

// File: rtl/cap_alloc_sequencer_if.sv
// Job bus of the allocation sequencer.
//   start/din/sw_vec : job request and operands (driven by the requester)
//   busy/done        : job status, done is a one-cycle pulse
//   dout/din_rem     : capacitor result and residual channel vector
//   used_cnt/overrun : consumed-channel count and sticky overrun flag
// master = requester side, slave = sequencer side.
interface cap_alloc_sequencer_if #(
    parameter int unsigned CHANNEL_NUM   = 128,
    parameter int unsigned CAPACITOR_NUM = 70
);
    localparam int unsigned CntW = $clog2(CHANNEL_NUM + 1);

    logic                     start;
    logic [CHANNEL_NUM-1:0]   din;
    logic [CAPACITOR_NUM-1:0] sw_vec;
    logic                     busy;
    logic                     done;
    logic [CAPACITOR_NUM-1:0] dout;
    logic [CHANNEL_NUM-1:0]   din_rem;
    logic [CntW-1:0]          used_cnt;
    logic                     overrun;

    modport master (
        output start, din, sw_vec,
        input  busy, done, dout, din_rem, used_cnt, overrun
    );

    modport slave (
        input  start, din, sw_vec,
        output busy, done, dout, din_rem, used_cnt, overrun
    );

endinterface

// File: rtl/cap_alloc_sequencer_step.sv
// One combinational allocation step.
//   din_i/dout_i/used_cnt_i : state before the step
//   sw_i                    : 1 = take a channel bit, 0 = shift in a 1
//   en_i                    : 0 passes all state through untouched
//   din_o/dout_o/used_cnt_o : state after the step
//   overrun_o               : this step wanted a channel but none were left
module cap_alloc_step #(
    parameter int unsigned CHANNEL_NUM   = 128,
    parameter int unsigned CAPACITOR_NUM = 70,
    parameter int unsigned CntW          = $clog2(CHANNEL_NUM + 1)
) (
    input  logic [CHANNEL_NUM-1:0]   din_i,
    input  logic [CAPACITOR_NUM-1:0] dout_i,
    input  logic                     sw_i,
    input  logic                     en_i,
    input  logic [CntW-1:0]          used_cnt_i,
    output logic [CHANNEL_NUM-1:0]   din_o,
    output logic [CAPACITOR_NUM-1:0] dout_o,
    output logic [CntW-1:0]          used_cnt_o,
    output logic                     overrun_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(CHANNEL_NUM);

    always_comb begin
        din_o      = din_i;
        dout_o     = dout_i;
        used_cnt_o = used_cnt_i;
        overrun_o  = 1'b0;
        if (en_i) begin
            if (sw_i) begin
                dout_o = {din_i[0], dout_i[CAPACITOR_NUM-1:1]};
                din_o  = {1'b1, din_i[CHANNEL_NUM-1:1]};
                // Counter saturates; extra takes only raise overrun.
                if (used_cnt_i < CntMax) begin
                    used_cnt_o = used_cnt_i + 1'b1;
                end else begin
                    overrun_o = 1'b1;
                end
            end else begin
                dout_o = {1'b1, dout_i[CAPACITOR_NUM-1:1]};
            end
        end
    end

endmodule

// File: rtl/cap_alloc_sequencer.sv
// Sequential channel-to-capacitor allocator.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : job interface (slave side): start/din/sw_vec in,
//              busy/done/dout/din_rem/used_cnt/overrun out (all registered)
// A job runs CAPACITOR_NUM steps, STEPS_PER_CYC per clock, through a chain of
// combinational step cells; the last beat is clamped so no step runs past
// index CAPACITOR_NUM-1.
module cap_alloc_sequencer
    import cap_alloc_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM   = 128,
    parameter int unsigned CAPACITOR_NUM = 70,
    parameter int unsigned STEPS_PER_CYC = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    cap_alloc_sequencer_if.slave bus
);

    localparam int unsigned CntW = cnt_w(CHANNEL_NUM);
    localparam int unsigned IdxW = idx_w(CAPACITOR_NUM);

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          step_idx_q, step_idx_d;
    logic [CAPACITOR_NUM-1:0] sw_q, sw_d;
    logic [CAPACITOR_NUM-1:0] dout_q, dout_d;
    logic [CHANNEL_NUM-1:0]   din_rem_q, din_rem_d;
    logic [CntW-1:0]          used_cnt_q, used_cnt_d;
    logic                     overrun_q, overrun_d;
    logic                     done_q, done_d;

    // Step chain: index 0 is the registered state, index STEPS_PER_CYC the result.
    logic [CHANNEL_NUM-1:0]   din_c  [STEPS_PER_CYC+1];
    logic [CAPACITOR_NUM-1:0] dout_c [STEPS_PER_CYC+1];
    logic [CntW-1:0]          cnt_c  [STEPS_PER_CYC+1];
    logic [STEPS_PER_CYC-1:0] step_en;
    logic [STEPS_PER_CYC-1:0] step_ovr;
    logic                     last_beat;

    assign din_c[0]  = din_rem_q;
    assign dout_c[0] = dout_q;
    assign cnt_c[0]  = used_cnt_q;

    for (genvar i = 0; i < STEPS_PER_CYC; i++) begin : g_step
        // sw_q is shifted down every beat, so cell i always reads bit i.
        assign step_en[i] = (32'(step_idx_q) + 32'(i)) < 32'(CAPACITOR_NUM);

        cap_alloc_step #(
            .CHANNEL_NUM   (CHANNEL_NUM),
            .CAPACITOR_NUM (CAPACITOR_NUM),
            .CntW          (CntW)
        ) u_step (
            .din_i      (din_c[i]),
            .dout_i     (dout_c[i]),
            .sw_i       (sw_q[i]),
            .en_i       (step_en[i]),
            .used_cnt_i (cnt_c[i]),
            .din_o      (din_c[i+1]),
            .dout_o     (dout_c[i+1]),
            .used_cnt_o (cnt_c[i+1]),
            .overrun_o  (step_ovr[i])
        );
    end

    assign last_beat = (32'(step_idx_q) + 32'(STEPS_PER_CYC)) >= 32'(CAPACITOR_NUM);

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        sw_d       = sw_q;
        dout_d     = dout_q;
        din_rem_d  = din_rem_q;
        used_cnt_d = used_cnt_q;
        overrun_d  = overrun_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StRun;
                    step_idx_d = '0;
                    sw_d       = bus.sw_vec;
                    dout_d     = '1;
                    din_rem_d  = bus.din;
                    used_cnt_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            StRun: begin
                dout_d     = dout_c[STEPS_PER_CYC];
                din_rem_d  = din_c[STEPS_PER_CYC];
                used_cnt_d = cnt_c[STEPS_PER_CYC];
                overrun_d  = overrun_q | (|step_ovr);
                sw_d       = sw_q >> STEPS_PER_CYC;
                if (last_beat) begin
                    step_idx_d = IdxW'(CAPACITOR_NUM);
                    state_d    = StIdle;
                    done_d     = 1'b1;
                end else begin
                    step_idx_d = step_idx_q + IdxW'(STEPS_PER_CYC);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            step_idx_q <= '0;
            sw_q       <= '0;
            dout_q     <= '1;
            din_rem_q  <= '0;
            used_cnt_q <= '0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            sw_q       <= sw_d;
            dout_q     <= dout_d;
            din_rem_q  <= din_rem_d;
            used_cnt_q <= used_cnt_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = done_q;
    assign bus.dout     = dout_q;
    assign bus.din_rem  = din_rem_q;
    assign bus.used_cnt = used_cnt_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_cap_alloc_sequencer.sv
// Directed bench: a small 8/5/2 instance for the main cases and a 4/6/4
// instance for overrun.
module tb_cap_alloc_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    cap_alloc_sequencer_if #(.CHANNEL_NUM(8), .CAPACITOR_NUM(5)) bus_s ();
    cap_alloc_sequencer_if #(.CHANNEL_NUM(4), .CAPACITOR_NUM(6)) bus_o ();

    cap_alloc_sequencer #(
        .CHANNEL_NUM   (8),
        .CAPACITOR_NUM (5),
        .STEPS_PER_CYC (2)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    cap_alloc_sequencer #(
        .CHANNEL_NUM   (4),
        .CAPACITOR_NUM (6),
        .STEPS_PER_CYC (4)
    ) u_ovr (
        .clk (clk),
        .rst (rst),
        .bus (bus_o.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a job on the small instance; returns clocks from accept edge to done.
    // Operands are scrambled after accept to show they are not re-sampled.
    task automatic run_small(input logic [7:0] d, input logic [4:0] s, output int lat);
        @(negedge clk);
        bus_s.start  = 1'b1;
        bus_s.din    = d;
        bus_s.sw_vec = s;
        @(negedge clk);
        bus_s.start  = 1'b0;
        bus_s.din    = ~d;
        bus_s.sw_vec = ~s;
        lat = 0;
        while (!bus_s.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({bus_s.busy, bus_s.done, bus_s.overrun} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus_s.busy, bus_s.done, bus_s.overrun});
        else passes++;
        checks++;
        if (bus_s.dout !== 5'b11111) $display("FAIL reset_dout: got %b want 11111", bus_s.dout);
        else passes++;
        checks++;
        if (bus_s.din_rem !== 8'h00 || bus_s.used_cnt !== 4'd0)
            $display("FAIL reset_rem_cnt: got %h/%0d want 00/0", bus_s.din_rem, bus_s.used_cnt);
        else passes++;
        checks++;
        if (bus_o.dout !== 6'b111111 || bus_o.busy !== 1'b0)
            $display("FAIL reset_ovr_inst: got %b/%b want 111111/0", bus_o.dout, bus_o.busy);
        else passes++;
    endtask

    task automatic test_all_sw;
        int lat;
        run_small(8'hA5, 5'b11111, lat);
        checks++;
        if (lat !== 3) $display("FAIL all_sw_latency: got %0d want 3", lat);
        else passes++;
        checks++;
        if (bus_s.dout !== 5'b00101) $display("FAIL all_sw_dout: got %b want 00101", bus_s.dout);
        else passes++;
        checks++;
        if (bus_s.din_rem !== 8'b11111101)
            $display("FAIL all_sw_rem: got %b want 11111101", bus_s.din_rem);
        else passes++;
        checks++;
        if (bus_s.used_cnt !== 4'd5 || bus_s.overrun !== 1'b0)
            $display("FAIL all_sw_cnt: got %0d/%b want 5/0", bus_s.used_cnt, bus_s.overrun);
        else passes++;
        checks++;
        if (bus_s.busy !== 1'b0) $display("FAIL all_sw_busy: got %b want 0", bus_s.busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus_s.done !== 1'b0 || bus_s.dout !== 5'b00101)
            $display("FAIL done_pulse_hold: got %b/%b want 0/00101", bus_s.done, bus_s.dout);
        else passes++;
    endtask

    task automatic test_no_sw;
        int lat;
        run_small(8'hA5, 5'b00000, lat);
        checks++;
        if (lat !== 3) $display("FAIL no_sw_latency: got %0d want 3", lat);
        else passes++;
        checks++;
        if (bus_s.dout !== 5'b11111 || bus_s.din_rem !== 8'hA5 || bus_s.used_cnt !== 4'd0)
            $display("FAIL no_sw_result: got %b/%h/%0d want 11111/a5/0",
                     bus_s.dout, bus_s.din_rem, bus_s.used_cnt);
        else passes++;
    endtask

    task automatic test_mixed;
        int lat;
        run_small(8'h03, 5'b10101, lat);
        checks++;
        if (lat !== 3) $display("FAIL mixed_latency: got %0d want 3", lat);
        else passes++;
        checks++;
        if (bus_s.dout !== 5'b01111 || bus_s.din_rem !== 8'hE0 || bus_s.used_cnt !== 4'd3)
            $display("FAIL mixed_result: got %b/%h/%0d want 01111/e0/3",
                     bus_s.dout, bus_s.din_rem, bus_s.used_cnt);
        else passes++;
    endtask

    task automatic test_overrun;
        int lat;
        @(negedge clk);
        bus_o.start  = 1'b1;
        bus_o.din    = 4'b0110;
        bus_o.sw_vec = 6'b111111;
        @(negedge clk);
        bus_o.start  = 1'b0;
        lat = 0;
        while (!bus_o.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 2) $display("FAIL ovr_latency: got %0d want 2", lat);
        else passes++;
        checks++;
        if (bus_o.dout !== 6'b110110) $display("FAIL ovr_dout: got %b want 110110", bus_o.dout);
        else passes++;
        checks++;
        if (bus_o.used_cnt !== 3'd4 || bus_o.overrun !== 1'b1)
            $display("FAIL ovr_flag: got %0d/%b want 4/1", bus_o.used_cnt, bus_o.overrun);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus_o.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", bus_o.overrun);
        else passes++;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        bus_s.start  = 1'b1;
        bus_s.din    = 8'hA5;
        bus_s.sw_vec = 5'b11111;
        @(negedge clk);
        // Start stays high with different operands during RUN: must be ignored.
        bus_s.din    = 8'hFF;
        bus_s.sw_vec = 5'b00000;
        lat = 0;
        while (!bus_s.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3) $display("FAIL b2b_job1_latency: got %0d want 3", lat);
        else passes++;
        checks++;
        if (bus_s.dout !== 5'b00101 || bus_s.din_rem !== 8'b11111101 || bus_s.used_cnt !== 4'd5)
            $display("FAIL b2b_job1_result: got %b/%h/%0d want 00101/fd/5",
                     bus_s.dout, bus_s.din_rem, bus_s.used_cnt);
        else passes++;
        // Present job 2 in the done cycle.
        bus_s.din    = 8'h03;
        bus_s.sw_vec = 5'b10101;
        @(negedge clk);
        bus_s.start  = 1'b0;
        checks++;
        if (bus_s.busy !== 1'b1) $display("FAIL b2b_no_bubble: got busy=%b want 1", bus_s.busy);
        else passes++;
        lat = 0;
        while (!bus_s.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3) $display("FAIL b2b_job2_latency: got %0d want 3", lat);
        else passes++;
        checks++;
        if (bus_s.dout !== 5'b01111 || bus_s.din_rem !== 8'hE0 || bus_s.used_cnt !== 4'd3)
            $display("FAIL b2b_job2_result: got %b/%h/%0d want 01111/e0/3",
                     bus_s.dout, bus_s.din_rem, bus_s.used_cnt);
        else passes++;
    endtask

    task automatic test_reset_midjob;
        int lat;
        int seen_done;
        @(negedge clk);
        bus_s.start  = 1'b1;
        bus_s.din    = 8'h5A;
        bus_s.sw_vec = 5'b11111;
        @(negedge clk);
        bus_s.start  = 1'b0;
        checks++;
        if (bus_s.busy !== 1'b1) $display("FAIL rst_mid_busy: got %b want 1", bus_s.busy);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_s.busy, bus_s.done, bus_s.overrun} !== 3'b000 || bus_s.dout !== 5'b11111)
            $display("FAIL rst_mid_async: got %b/%b want 000/11111",
                     {bus_s.busy, bus_s.done, bus_s.overrun}, bus_s.dout);
        else passes++;
        checks++;
        if (bus_s.din_rem !== 8'h00 || bus_s.used_cnt !== 4'd0)
            $display("FAIL rst_mid_rem_cnt: got %h/%0d want 00/0", bus_s.din_rem, bus_s.used_cnt);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus_s.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen_done);
        else passes++;
        run_small(8'hA5, 5'b11111, lat);
        checks++;
        if (lat !== 3 || bus_s.dout !== 5'b00101 || bus_s.used_cnt !== 4'd5)
            $display("FAIL rst_mid_rerun: got %0d/%b/%0d want 3/00101/5",
                     lat, bus_s.dout, bus_s.used_cnt);
        else passes++;
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        rst          = 1'b1;
        bus_s.start  = 1'b0;
        bus_s.din    = '0;
        bus_s.sw_vec = '0;
        bus_o.start  = 1'b0;
        bus_o.din    = '0;
        bus_o.sw_vec = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_all_sw();
        test_no_sw();
        test_mixed();
        test_overrun();
        test_back_to_back();
        test_reset_midjob();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
